// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: FSM states and instruction sizing.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } pc_state_e;

  localparam int INSTR_BYTES  = 4;
  localparam int OFFSET_SHIFT = 2;

endpackage

// File: rtl/pc_target_adder.sv
// Branch target computation: word offset scaled to bytes, 32-bit wrap-around.
module pc_target_adder
  import pc_seq_pkg::*;
(
  input  logic [31:0] BranchBase,
  input  logic [31:0] Offset,
  output logic [31:0] target
);

  assign target = BranchBase + (Offset << OFFSET_SHIFT);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: issues fetch requests, holds one pending branch
// target while a request is outstanding, and counts taken branches.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             BranchValid,
  input  logic             Branch,
  input  logic             Zero,
  input  logic [31:0]      BranchBase,
  input  logic [31:0]      Offset,
  input  logic             Stall,
  input  logic             Halt,
  input  logic             FetchReady,
  output logic             FetchValid,
  output logic [31:0]      FetchAddr,
  output logic             Redirected,
  output logic [CNT_W-1:0] TakenCount,
  output logic             Halted
);

  localparam logic [31:0] RESET_PC_AL = RESET_PC & 32'hFFFF_FFFC;

  pc_state_e        state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             outst_q, outst_d;
  logic             redir_q, redir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      target;
  logic             taken;
  logic             fetch_valid;
  logic             accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  pc_target_adder u_target (
    .BranchBase (BranchBase),
    .Offset     (Offset),
    .target     (target)
  );

  assign taken       = BranchValid & Branch & Zero;
  // An outstanding request stays presented until accepted; new ones need !Stall and !Halt.
  assign fetch_valid = (state_q == FETCH) & (outst_q | (~Stall & ~Halt));
  assign accept      = fetch_valid & FetchReady;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    redir_d    = 1'b0;
    outst_d    = fetch_valid & ~FetchReady;
    cnt_d      = taken ? sat_inc(cnt_q) : cnt_q;

    if (accept) begin
      if (pend_vld_q) begin
        pc_d       = pend_q;
        pend_vld_d = 1'b0;
        redir_d    = 1'b1;
      end else begin
        pc_d = pc_q + 32'(INSTR_BYTES);
      end
    end

    // A held pending target is older and wins; later taken branches only count.
    if (taken && !pend_vld_q) begin
      if (fetch_valid && !FetchReady) begin
        pend_d     = target;
        pend_vld_d = 1'b1;
      end else begin
        pc_d    = target;
        redir_d = 1'b1;
      end
    end

    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (Halt && (!outst_q || accept)) state_d = HALTED;
      HALTED:  if (!Halt) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC_AL;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      outst_q    <= 1'b0;
      redir_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      outst_q    <= outst_d;
      redir_q    <= redir_d;
      cnt_q      <= cnt_d;
    end
  end

  assign FetchValid = fetch_valid;
  assign FetchAddr  = pc_q;
  assign Redirected = redir_q;
  assign TakenCount = cnt_q;
  assign Halted     = (state_q == HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer plus hand-written corner sequences.
module tb_pc_sequencer;

  localparam int CNT_W = 4;

  logic             Clock;
  logic             Reset_n;
  logic             BranchValid, Branch, Zero;
  logic [31:0]      BranchBase, Offset;
  logic             Stall, Halt, FetchReady;
  logic             FetchValid;
  logic [31:0]      FetchAddr;
  logic             Redirected;
  logic [CNT_W-1:0] TakenCount;
  logic             Halted;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .BranchValid (BranchValid),
    .Branch      (Branch),
    .Zero        (Zero),
    .BranchBase  (BranchBase),
    .Offset      (Offset),
    .Stall       (Stall),
    .Halt        (Halt),
    .FetchReady  (FetchReady),
    .FetchValid  (FetchValid),
    .FetchAddr   (FetchAddr),
    .Redirected  (Redirected),
    .TakenCount  (TakenCount),
    .Halted      (Halted)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic             rst_n, bv, br, z;
    logic [31:0]      base, off;
    logic             stall, halt, rdy;
    logic             efv;
    logic [31:0]      eaddr;
    logic             eredir;
    logic [CNT_W-1:0] ecnt;
    logic             ehalt;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic rst_n, bv, br, z,
                              input logic [31:0] base, off,
                              input logic stall, halt, rdy,
                              input logic efv, input logic [31:0] eaddr,
                              input logic eredir, input logic [CNT_W-1:0] ecnt,
                              input logic ehalt);
    vec_t v;
    v.rst_n = rst_n; v.bv = bv; v.br = br; v.z = z;
    v.base = base; v.off = off;
    v.stall = stall; v.halt = halt; v.rdy = rdy;
    v.efv = efv; v.eaddr = eaddr; v.eredir = eredir; v.ecnt = ecnt; v.ehalt = ehalt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @vec %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst_n, bv, br, z, input logic [31:0] base, off,
                       input logic stall, halt, rdy);
    Reset_n = rst_n; BranchValid = bv; Branch = br; Zero = z;
    BranchBase = base; Offset = off; Stall = stall; Halt = halt; FetchReady = rdy;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset release with FetchReady held: 0,4,8,C
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,1, 0,32'h0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,1, 0,32'h0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,1, 1,32'h0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,1, 1,32'h4,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,1, 1,32'h8,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,1, 1,32'hC,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,1, 1,32'h10,0,0,0));
    // Held request at 8 with a taken branch to 1C
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,1, 0,32'h0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,1, 0,32'h0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,1, 1,32'h0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,1, 1,32'h4,0,0,0));
    vecs.push_back(mk(1,1,1,1, 32'hC,32'h4, 0,0,0, 1,32'h8,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 1,0,0, 1,32'h8,0,1,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,0, 1,32'h8,0,1,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,1, 1,32'h8,0,1,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,1, 1,32'h1C,1,1,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,1, 1,32'h20,0,1,0));
    // Two taken branches while held at 10: first (40) wins
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,1, 0,32'h0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,1, 0,32'h0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,1, 1,32'h0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,1, 1,32'h4,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,1, 1,32'h8,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,1, 1,32'hC,0,0,0));
    vecs.push_back(mk(1,1,1,1, 32'h20,32'h8, 0,0,0, 1,32'h10,0,0,0));
    vecs.push_back(mk(1,1,1,1, 32'h40,32'h10, 0,0,0, 1,32'h10,0,1,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,1, 1,32'h10,0,2,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,1, 1,32'h40,1,2,0));
    // Negative offset wraps target to FFFFFFFC, then PC+4 wraps to 0
    vecs.push_back(mk(1,1,1,1, 32'h0,32'hFFFF_FFFF, 1,0,0, 0,32'h44,0,2,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,1, 1,32'hFFFF_FFFC,1,3,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,1, 1,32'h0,0,3,0));
    // Halt with a request outstanding, then resume at next PC
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,0, 1,32'h4,0,3,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,1,0, 1,32'h4,0,3,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 1,1,0, 1,32'h4,0,3,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,1,1, 1,32'h4,0,3,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,1,1, 0,32'h8,0,3,1));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,1, 0,32'h8,0,3,1));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,1, 1,32'h8,0,3,0));
    // Halt with nothing outstanding; taken branch while halted loads PC
    vecs.push_back(mk(1,0,0,0, 0,0, 0,1,1, 0,32'hC,0,3,0));
    vecs.push_back(mk(1,1,1,1, 32'h100,32'h0, 0,1,1, 0,32'hC,0,3,1));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,1, 0,32'h100,1,4,1));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,1, 1,32'h100,0,4,0));
    // Taken coinciding with accept beats PC+4; non-taken branches ignored
    vecs.push_back(mk(1,1,1,1, 32'h200,32'h1, 0,0,1, 1,32'h104,0,4,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,1, 1,32'h204,1,5,0));
    vecs.push_back(mk(1,1,0,1, 32'h300,32'h0, 0,0,1, 1,32'h208,0,5,0));
    vecs.push_back(mk(1,1,1,0, 32'h300,32'h0, 0,0,1, 1,32'h20C,0,5,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,0, 1,32'h210,0,5,0));
    // Reset mid-handshake drops FetchValid at once
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,0, 0,32'h0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,0, 0,32'h0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,1, 1,32'h0,0,0,0));

    foreach (vecs[i]) begin
      @(negedge Clock);
      drive(vecs[i].rst_n, vecs[i].bv, vecs[i].br, vecs[i].z, vecs[i].base, vecs[i].off,
            vecs[i].stall, vecs[i].halt, vecs[i].rdy);
      #1;
      n_vec++;
      chk("FetchValid", i, 32'(FetchValid), 32'(vecs[i].efv));
      chk("FetchAddr",  i, FetchAddr,        vecs[i].eaddr);
      chk("Redirected", i, 32'(Redirected), 32'(vecs[i].eredir));
      chk("TakenCount", i, 32'(TakenCount), 32'(vecs[i].ecnt));
      chk("Halted",     i, 32'(Halted),     32'(vecs[i].ehalt));
    end

    // Counter saturation: 20 taken branches with Stall high, each loading PC=0
    for (int k = 0; k < 20; k++) begin
      @(negedge Clock);
      drive(1, 1, 1, 1, 32'h0, 32'h0, 1, 0, 0);
    end
    @(negedge Clock);
    #1;
    n_vec++;
    chk("sat_count", 1000, 32'(TakenCount), 32'hF);
    @(negedge Clock);
    #1;
    n_vec++;
    chk("sat_hold",       1001, 32'(TakenCount), 32'hF);
    chk("sat_fetchvalid", 1001, 32'(FetchValid), 32'h0);
    chk("sat_addr",       1001, FetchAddr,       32'h0);
    chk("sat_redir",      1001, 32'(Redirected), 32'h1);

    // Reset clears the counter; first request appears within a bounded wait
    @(negedge Clock);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    n_vec++;
    chk("rst_count", 1002, 32'(TakenCount), 32'h0);
    @(negedge Clock);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 4 && !seen; k++) begin
        @(negedge Clock);
        #1;
        if (FetchValid === 1'b1) seen = 1'b1;
      end
      n_vec++;
      if (!seen) begin
        n_err++;
        $display("FAIL fetch_after_reset: FetchValid never rose within 4 cycles, expected 1");
      end else begin
        chk("fetch_after_reset_addr", 1003, FetchAddr, 32'h0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC loaded on reset; bits [1:0] are ignored and forced to 0.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the taken-branch counter.
REQ-003 SHALL have port Clock  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port BranchValid  input  1  one-cycle pulse: a branch was resolved this cycle.
REQ-006 SHALL have port Branch  input  1  the resolved instruction is a conditional branch.
REQ-007 SHALL have port Zero  input  1  ALU zero flag for the resolved branch.
REQ-008 SHALL have port BranchBase  input  32  PC+4 of the resolved branch.
REQ-009 SHALL have port Offset  input  32  sign-extended word offset of the branch.
REQ-010 SHALL have port Stall  input  1  blocks issue of a new fetch request.
REQ-011 SHALL have port Halt  input  1  level request to stop fetching.
REQ-012 SHALL have port FetchReady  input  1  instruction memory accepts the request.
REQ-013 SHALL have port FetchValid  output  1  a fetch request is presented.
REQ-014 SHALL have port FetchAddr  output  32  word-aligned fetch address, equal to PC.
REQ-015 SHALL have port Redirected  output  1  one-cycle pulse: PC loaded from a branch target.
REQ-016 SHALL have port TakenCount  output  CNT_W  number of taken branches, saturating.
REQ-017 SHALL have port Halted  output  1  high while in state HALTED.

Function
REQ-018 SHALL have three states: IDLE (reset), FETCH, HALTED.
REQ-019 SHALL go from IDLE to FETCH on the first clock edge after Reset_n deasserts; FetchValid is 0 while in IDLE.
REQ-020 SHALL define taken = BranchValid & Branch & Zero, and target = BranchBase + (Offset << 2), with 32-bit wrap-around and no overflow flag.
REQ-021 SHALL, in FETCH, raise FetchValid only when Stall=0, and once raised hold FetchValid=1 and FetchAddr stable until FetchReady=1, regardless of Stall, Halt or taken.
REQ-022 SHALL define accept = FetchValid & FetchReady; on accept, PC becomes the pending target if one is held, otherwise PC+4 (wrapping 32'hFFFF_FFFC to 0).
REQ-023 SHALL capture a taken branch into a one-entry pending-target register while a request is outstanding and not accepted that cycle.
REQ-024 SHALL load a taken target into PC on the next edge, with no capture, when no request is outstanding or accept occurs in the same cycle.
REQ-025 SHALL, when taken and accept coincide, let the taken target win over PC+4.
REQ-026 SHALL ignore a taken branch arriving while a pending target is already held (the older branch wins); TakenCount still increments.
REQ-027 SHALL pulse Redirected for exactly one cycle, in the cycle after PC is loaded from a target.
REQ-028 SHALL increment TakenCount by 1 per taken and hold it at all-ones once saturated.
REQ-029 SHALL move from FETCH to HALTED when Halt=1 and no request is outstanding, or on an accept while Halt=1; no new request issues after that.
REQ-030 SHALL, in HALTED, keep FetchValid=0 and Halted=1, while still capturing taken branches into pending or PC.
REQ-031 SHALL move from HALTED to FETCH on the edge after Halt=0; a request may issue in that FETCH cycle.
REQ-032 SHALL ignore BranchValid with Branch=0, or with Zero=0, apart from having no effect.

Reset
REQ-033 SHALL, on Reset_n=0, immediately and asynchronously set PC=RESET_PC&~3, state IDLE, FetchValid=0, Redirected=0, pending cleared, TakenCount=0, Halted=0.
REQ-034 SHALL abandon any outstanding request when reset asserts mid-handshake; the memory side shall not expect completion.

Structure
REQ-035 SHALL place the state enum, INSTR_BYTES=4 and the shift amount of 2 in shared package pc_seq_pkg.
REQ-036 SHALL compute target in sub-module pc_target_adder: combinational, inputs BranchBase and Offset, output target.

Verification
REQ-037 SHALL cover reset release with FetchReady=1 held: FetchAddr sequence 0,4,8,C from the second cycle after release; Redirected=0.
REQ-038 SHALL cover FetchReady=0 for 3 cycles at FetchAddr=8 while a taken branch arrives (BranchBase=C, Offset=4): FetchAddr stays 8; after accept the next FetchAddr=1C; Redirected pulses once.
REQ-039 SHALL cover two taken branches on consecutive cycles while stalled at FetchAddr=10 (targets 40, 80): FetchAddr 40 follows; TakenCount=2.
REQ-040 SHALL cover Offset=32'hFFFF_FFFF with BranchBase=0: target=32'hFFFF_FFFC; the next sequential FetchAddr wraps to 0.
REQ-041 SHALL cover Halt=1 asserted with a request outstanding: request held until FetchReady, then Halted=1 and FetchValid=0; Halt=0 resumes at the next PC.
REQ-042 SHALL cover Reset_n pulsed low mid-handshake with FetchValid=1: FetchValid drops immediately; PC=RESET_PC; TakenCount=0.
